add_arb: RTL



---
 rtl/add_arb_if.sv | 32 +++
 rtl/add_arb.sv | 130 +++++++++++++
 2 files changed

// File: rtl/add_arb_if.sv
// Bundle between add_arb, its requesters, the shared adder and the result consumer.
// Modport master is the arbiter side; slave is the environment side.
interface add_arb_if #(
    parameter int unsigned N    = 8,
    parameter int unsigned NREQ = 4
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req_i;
    logic [NREQ*N-1:0] data0_i;
    logic [NREQ*N-1:0] data1_i;
    logic [NREQ-1:0]   gnt_o;
    logic [N-1:0]      add_a_o;
    logic [N-1:0]      add_b_o;
    logic [N-1:0]      add_sum_i;
    logic              add_over_i;
    logic              res_valid_o;
    logic [IDW-1:0]    res_id_o;
    logic [N-1:0]      sum_o;
    logic              over_o;
    logic              res_ready_i;

    modport master (
        input  req_i, data0_i, data1_i, add_sum_i, add_over_i, res_ready_i,
        output gnt_o, add_a_o, add_b_o, res_valid_o, res_id_o, sum_o, over_o
    );

    modport slave (
        output req_i, data0_i, data1_i, add_sum_i, add_over_i, res_ready_i,
        input  gnt_o, add_a_o, add_b_o, res_valid_o, res_id_o, sum_o, over_o
    );
endinterface

// File: rtl/add_arb.sv
// Round-robin arbiter sharing one external fixed-latency adder between NREQ requesters.
// Optional ADD_ARB_SAT_EN: saturate sum_o to all ones when the adder reports carry-out.
module add_arb #(
    parameter int unsigned N    = 8,
    parameter int unsigned NREQ = 4,
    parameter int unsigned LAT  = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    add_arb_if.master  bus
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW  = (LAT > 0) ? $clog2(LAT + 1) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic            valid_q, valid_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [N-1:0]    sum_q, sum_d;
    logic            over_q, over_d;

    logic            found;
    logic [IDW-1:0]  sel;
    logic [IDW-1:0]  cand;
    int unsigned     idx;

    // First active request scanning from ptr upward with wrap.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = IDW'(idx);
            if (!found && bus.req_i[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // EXEC runs LAT+1 cycles so the adder result is settled when sampled.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        a_d     = a_q;
        b_d     = b_q;
        valid_d = valid_q;
        id_d    = id_q;
        sum_d   = sum_q;
        over_d  = over_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = NREQ'(1) << sel;
                    a_d     = bus.data0_i[32'(sel)*N +: N];
                    b_d     = bus.data1_i[32'(sel)*N +: N];
                    id_d    = sel;
                    cnt_d   = CW'(LAT);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    sum_d   = bus.add_sum_i;
                    over_d  = bus.add_over_i;
`ifdef ADD_ARB_SAT_EN
                    if (bus.add_over_i) sum_d = '1;
`endif
                    valid_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.res_ready_i) begin
                    valid_d = 1'b0;
                    ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            sum_q   <= '0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            over_q  <= over_d;
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.add_a_o     = a_q;
    assign bus.add_b_o     = b_q;
    assign bus.res_valid_o = valid_q;
    assign bus.res_id_o    = id_q;
    assign bus.sum_o       = sum_q;
    assign bus.over_o      = over_q;
endmodule
